// File: rtl/bcd_conv_arbiter.sv
// Round-robin arbiter sharing one BCD converter between N_REQ requesters.
// Optional conversion watchdog enabled by defining BCD_ARB_TIMEOUT_EN.
module bcd_conv_arbiter #(
  parameter  int N_REQ          = 4,
  parameter  int DATA_IN_WIDTH  = 16,
  parameter  int DATA_OUT_WIDTH = 20,
  parameter  int TIMEOUT_CYCLES = 256,
  localparam int CH_W           = $clog2(N_REQ)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [N_REQ-1:0]               req_i,
  input  logic [N_REQ*DATA_IN_WIDTH-1:0] data_i,
  output logic [N_REQ-1:0]               ack_o,
  output logic [DATA_OUT_WIDTH-1:0]      result_o,
  output logic [CH_W-1:0]                result_ch_o,
  output logic                           err_o,
  output logic                           conv_en_o,
  output logic [DATA_IN_WIDTH-1:0]       conv_data_o,
  input  logic                           conv_busy_i,
  input  logic                           conv_rdy_i,
  input  logic [DATA_OUT_WIDTH-1:0]      conv_res_i
);

  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
    $error("bcd_conv_arbiter: N_REQ must be 2..8 and TIMEOUT_CYCLES >= 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_BUSY,
    S_WAIT_RDY,
    S_ACK
  } state_t;

  state_t                    state_q, state_d;
  logic [CH_W-1:0]           ptr_q, ptr_d;
  logic [CH_W-1:0]           grant_q, grant_d;
  logic [N_REQ-1:0]          ack_q, ack_d;
  logic [DATA_OUT_WIDTH-1:0] result_q, result_d;
  logic [CH_W-1:0]           result_ch_q, result_ch_d;
  logic                      err_q, err_d;
  logic                      conv_en_q, conv_en_d;
  logic [DATA_IN_WIDTH-1:0]  conv_data_q, conv_data_d;

  logic                      rr_valid;
  logic [CH_W-1:0]           rr_idx;
  logic                      tmo_hit;
  logic                      done;
  logic                      timed_out;

`ifdef BCD_ARB_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  assign tmo_hit = (tmo_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  // Scan downward so the lowest offset from ptr_q is the last (winning) match.
  always_comb begin
    rr_valid = 1'b0;
    rr_idx   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      int idx;
      idx = (int'(ptr_q) + i) % N_REQ;
      if (req_i[idx]) begin
        rr_valid = 1'b1;
        rr_idx   = CH_W'(idx);
      end
    end
  end

  always_comb begin
    // NOTE: every _d gets a default before the case so no path leaves it unassigned (no latches).
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    ack_d       = '0;
    result_d    = result_q;
    result_ch_d = result_ch_q;
    err_d       = err_q;
    conv_en_d   = 1'b0;
    conv_data_d = conv_data_q;
    done        = 1'b0;
    timed_out   = 1'b0;
`ifdef BCD_ARB_TIMEOUT_EN
    tmo_cnt_d   = tmo_cnt_q;
    if (state_q == S_WAIT_BUSY || state_q == S_WAIT_RDY) tmo_cnt_d = tmo_cnt_q + 1'b1;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (rr_valid && !conv_busy_i) begin
          grant_d     = rr_idx;
          conv_data_d = data_i[int'(rr_idx)*DATA_IN_WIDTH +: DATA_IN_WIDTH];
          conv_en_d   = 1'b1;
          state_d     = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        state_d = S_WAIT_BUSY;
`ifdef BCD_ARB_TIMEOUT_EN
        tmo_cnt_d = '0;
`endif
      end
      S_WAIT_BUSY: begin
        // Waiting for busy first keeps a stale rdy from the previous job from completing this one.
        if (tmo_hit) begin
          done      = 1'b1;
          timed_out = 1'b1;
        end else if (conv_busy_i) begin
          state_d = S_WAIT_RDY;
        end
      end
      S_WAIT_RDY: begin
        if (conv_rdy_i) begin
          done = 1'b1;
        end else if (tmo_hit) begin
          done      = 1'b1;
          timed_out = 1'b1;
        end
      end
      S_ACK: begin
        ptr_d   = (int'(grant_q) == N_REQ - 1) ? '0 : grant_q + 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (done) begin
      state_d         = S_ACK;
      ack_d[grant_q]  = 1'b1;
      result_d        = timed_out ? '0 : conv_res_i;
      result_ch_d     = grant_q;
      err_d           = timed_out;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      grant_q     <= '0;
      ack_q       <= '0;
      result_q    <= '0;
      result_ch_q <= '0;
      err_q       <= 1'b0;
      conv_en_q   <= 1'b0;
      conv_data_q <= '0;
`ifdef BCD_ARB_TIMEOUT_EN
      tmo_cnt_q   <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge value of the others.
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      ack_q       <= ack_d;
      result_q    <= result_d;
      result_ch_q <= result_ch_d;
      err_q       <= err_d;
      conv_en_q   <= conv_en_d;
      conv_data_q <= conv_data_d;
`ifdef BCD_ARB_TIMEOUT_EN
      tmo_cnt_q   <= tmo_cnt_d;
`endif
    end
  end

  assign ack_o       = ack_q;
  assign result_o    = result_q;
  assign result_ch_o = result_ch_q;
  assign err_o       = err_q;
  assign conv_en_o   = conv_en_q;
  assign conv_data_o = conv_data_q;

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Directed bench for bcd_conv_arbiter with a behavioural converter model.
// Define BCD_ARB_TIMEOUT_EN to also exercise the watchdog path.
module tb_bcd_conv_arbiter;

  localparam int N   = 4;
  localparam int DW  = 16;
  localparam int OW  = 20;
  localparam int LAT = 100;
`ifdef BCD_ARB_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 256;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req;
  logic [N*DW-1:0] data;
  logic [N-1:0]    ack_o;
  logic [OW-1:0]   result_o;
  logic [1:0]      result_ch_o;
  logic            err_o;
  logic            conv_en_o;
  logic [DW-1:0]   conv_data_o;
  logic            busy_m, rdy_m;
  logic [OW-1:0]   res_m, pend_m;
  int              cnt_m;
  bit              hang_m;

  int n_checks = 0;
  int n_fail   = 0;
  int en_cnt   = 0;
  int ack_cnt  = 0;
  int viol_cnt = 0;

  always #5 clk = ~clk;

  bcd_conv_arbiter #(
    .N_REQ(N), .DATA_IN_WIDTH(DW), .DATA_OUT_WIDTH(OW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req), .data_i(data),
    .ack_o(ack_o), .result_o(result_o), .result_ch_o(result_ch_o), .err_o(err_o),
    .conv_en_o(conv_en_o), .conv_data_o(conv_data_o),
    .conv_busy_i(busy_m), .conv_rdy_i(rdy_m), .conv_res_i(res_m)
  );

  function automatic logic [OW-1:0] to_bcd(input logic [DW-1:0] v);
    logic [OW-1:0] r;
    int x;
    r = '0;
    x = int'(v);
    for (int d = 0; d < 5; d++) begin
      r[d*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Converter model: busy the cycle after en, rdy/result about LAT cycles later.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_m <= 1'b0;
      rdy_m  <= 1'b0;
      res_m  <= '0;
      pend_m <= '0;
      cnt_m  <= 0;
    end else if (conv_en_o) begin
      busy_m <= 1'b1;
      rdy_m  <= 1'b0;
      pend_m <= to_bcd(conv_data_o);
      cnt_m  <= LAT;
    end else if (busy_m) begin
      if (cnt_m == 0) begin
        busy_m <= 1'b0;
        if (!hang_m) begin
          rdy_m <= 1'b1;
          res_m <= pend_m;
        end
      end else begin
        cnt_m <= cnt_m - 1;
      end
    end
  end

  always @(posedge clk) begin
    if (conv_en_o) en_cnt <= en_cnt + 1;
    if (ack_o != '0) ack_cnt <= ack_cnt + 1;
    if (conv_en_o && busy_m) viol_cnt <= viol_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_data(input int ch, input logic [DW-1:0] v);
    data[ch*DW +: DW] = v;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input string tag, input int budget, output int ch, output int waited);
    logic got;
    got    = 1'b0;
    ch     = -1;
    waited = 0;
    for (int i = 1; i <= budget && !got; i++) begin
      tick();
      if (ack_o != '0) begin
        got    = 1'b1;
        waited = i;
        for (int b = 0; b < N; b++) if (ack_o[b]) ch = b;
      end
    end
    check({tag, "_ack_in_time"}, 32'(got), 32'd1);
    if (got) check({tag, "_ack_onehot"}, 32'($countones(ack_o)), 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ack"},       32'(ack_o),       32'd0);
    check({tag, "_result"},    32'(result_o),    32'd0);
    check({tag, "_result_ch"}, 32'(result_ch_o), 32'd0);
    check({tag, "_err"},       32'(err_o),       32'd0);
    check({tag, "_conv_en"},   32'(conv_en_o),   32'd0);
    check({tag, "_conv_data"}, 32'(conv_data_o), 32'd0);
  endtask

  initial begin
    int ch, waited, e0, a0;
    logic [OW-1:0] exp2 [4];
    int            seq3 [3];
    logic [OW-1:0] res3 [3];
    exp2 = '{20'h00000, 20'h00009, 20'h65535, 20'h00042};
    seq3 = '{3, 1, 3};
    res3 = '{20'h00321, 20'h00007, 20'h00321};

    rst_n  = 1'b0;
    req    = '0;
    data   = '0;
    hang_m = 1'b0;
    repeat (3) tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // 1. single request on ch2, with en latency and single-pulse checks
    set_data(2, 16'd1234);
    req = 4'b0100;
    e0  = en_cnt;
    tick();
    check("t1_en_latency", 32'(conv_en_o), 32'd1);
    check("t1_conv_data", 32'(conv_data_o), 32'd1234);
    tick();
    check("t1_en_one_cycle", 32'(conv_en_o), 32'd0);
    wait_ack("t1", 400, ch, waited);
    check("t1_ack", 32'(ack_o), 32'b0100);
    check("t1_result", 32'(result_o), 32'h01234);
    check("t1_result_ch", 32'(result_ch_o), 32'd2);
    check("t1_err", 32'(err_o), 32'd0);
    req = '0;
    tick();
    check("t1_ack_pulse", 32'(ack_o), 32'd0);
    check("t1_en_count", 32'(en_cnt - e0), 32'd1);
    check("t1_result_held", 32'(result_o), 32'h01234);

    // 2. all four requesting from ptr=0
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    tick();
    set_data(0, 16'd0);
    set_data(1, 16'd9);
    set_data(2, 16'd65535);
    set_data(3, 16'd42);
    req = 4'hF;
    for (int k = 0; k < 4; k++) begin
      wait_ack("t2", 400, ch, waited);
      check("t2_order", 32'(ch), 32'(k));
      check("t2_result", 32'(result_o), 32'(exp2[k]));
      check("t2_result_ch", 32'(result_ch_o), 32'(k));
      if (ch >= 0) req[ch] = 1'b0;
    end

    // 3. ch1 and ch3 held continuously after ch1 is served
    set_data(1, 16'd7);
    set_data(3, 16'd321);
    req = 4'b0010;
    wait_ack("t3a", 400, ch, waited);
    check("t3_first", 32'(ch), 32'd1);
    req = 4'b1010;
    for (int k = 0; k < 3; k++) begin
      wait_ack("t3", 400, ch, waited);
      check("t3_order", 32'(ch), 32'(seq3[k]));
      check("t3_result", 32'(result_o), 32'(res3[k]));
    end
    req = '0;
    tick();

    // 5. operand change after grant must not leak into the conversion
    set_data(0, 16'd100);
    req = 4'b0001;
    repeat (20) tick();
    set_data(0, 16'd200);
    tick();
    check("t5_conv_data_stable", 32'(conv_data_o), 32'd100);
    wait_ack("t5", 400, ch, waited);
    check("t5_ch", 32'(ch), 32'd0);
    check("t5_result", 32'(result_o), 32'h00100);
    req = '0;
    tick();

    // 4. reset in the middle of WAIT_RDY (ptr is 1 beforehand)
    set_data(2, 16'd5);
    req = 4'b0100;
    repeat (20) tick();
    a0 = ack_cnt;
    rst_n = 1'b0;
    #1;
    check_all_zero("t4_reset");
    tick();
    rst_n = 1'b1;
    req   = '0;
    repeat (LAT + 30) tick();
    check("t4_no_ack", 32'(ack_cnt - a0), 32'd0);
    set_data(0, 16'd11);
    set_data(1, 16'd22);
    set_data(3, 16'd33);
    req = 4'hF;
    wait_ack("t4", 400, ch, waited);
    check("t4_ptr_reset", 32'(ch), 32'd0);
    check("t4_result", 32'(result_o), 32'h00011);
    req = '0;
    repeat (2) tick();

`ifdef BCD_ARB_TIMEOUT_EN
    // 6. converter never raises rdy: watchdog acks with err after 16 wait cycles
    begin
      logic en_seen;
      logic idle_seen;
      hang_m = 1'b1;
      set_data(0, 16'd77);
      req     = 4'b0001;
      en_seen = 1'b0;
      for (int i = 0; i < 50 && !en_seen; i++) begin
        tick();
        if (conv_en_o) en_seen = 1'b1;
      end
      check("t6_en_seen", 32'(en_seen), 32'd1);
      wait_ack("t6", 400, ch, waited);
      check("t6_wait_cycles", 32'(waited), 32'd17);
      check("t6_err", 32'(err_o), 32'd1);
      check("t6_result", 32'(result_o), 32'd0);
      check("t6_result_ch", 32'(result_ch_o), 32'd0);
      req    = '0;
      hang_m = 1'b0;
      idle_seen = 1'b0;
      for (int i = 0; i < 300 && !idle_seen; i++) begin
        tick();
        if (!busy_m) idle_seen = 1'b1;
      end
      check("t6_conv_idle", 32'(idle_seen), 32'd1);
      check("t6_err_held", 32'(err_o), 32'd1);
      set_data(1, 16'd55);
      req = 4'b0010;
      wait_ack("t6b", 400, ch, waited);
      check("t6_err_cleared", 32'(err_o), 32'd0);
      check("t6b_result", 32'(result_o), 32'h00055);
      req = '0;
      tick();
    end
`endif

    check("no_en_while_busy", 32'(viol_cnt), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
